// File: rtl/fsm_alu_mc_if.sv
// fsm_alu_mc_if: instruction/handshake bundle between the sequencing
// controller and its datapath.
//   insn, code     : current instruction and its one-hot opcode class
//   start, md_done : leave-IDLE request and mul/div result-valid pulse
//   load_*, sel_*, sub_sra, md_start, md_op, done, trap : controller outputs
// The controller connects via the slave modport; the datapath side via master.
interface fsm_alu_mc_if;
    logic [31:0] insn;
    logic [31:0] code;
    logic        start;
    logic        md_done;
    logic        load_pc;
    logic        load_regfile;
    logic        load_rs1;
    logic        load_rs2;
    logic        load_alu;
    logic        load_imm;
    logic        sel_alu_a;
    logic        sel_alu_b;
    logic        sel_alu_32b;
    logic        sub_sra;
    logic        md_start;
    logic [2:0]  md_op;
    logic        sel_wb_md;
    logic        done;
    logic        trap;

    modport master (
        output insn, code, start, md_done,
        input  load_pc, load_regfile, load_rs1, load_rs2, load_alu, load_imm,
               sel_alu_a, sel_alu_b, sel_alu_32b, sub_sra,
               md_start, md_op, sel_wb_md, done, trap
    );

    modport slave (
        input  insn, code, start, md_done,
        output load_pc, load_regfile, load_rs1, load_rs2, load_alu, load_imm,
               sel_alu_a, sel_alu_b, sel_alu_32b, sub_sra,
               md_start, md_op, sel_wb_md, done, trap
    );
endinterface

// File: rtl/fsm_alu_mc.sv
// fsm_alu_mc: multi-cycle controller sequencing one ALU or mul/div
// instruction at a time: IDLE -> DECODE -> EXEC_R/EXEC_I (or MD_ISSUE ->
// MD_WAIT) -> WRITEBACK (WB_HOLD cycles) -> DONE, with TRAP for illegal or
// timed-out instructions.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fsm_alu_mc_if.slave (insn/code/start/md_done in, controls out)
// Parameters: XLEN (32|64), MD_TIMEOUT (1..255), WB_HOLD (1..4).
// Build option: define FSM_ALU_MULDIV_EN to include the mul/div path;
// without it mul/div encodings trap and md_start/md_op/sel_wb_md stay 0.
module fsm_alu_mc #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned WB_HOLD    = 1
) (
    input  logic        clk,
    input  logic        rst,
    fsm_alu_mc_if.slave bus
);
    // 32-bit word ops exist only on a 64-bit datapath
    localparam bit         W_OK    = (XLEN != 32);
    localparam logic [1:0] WB_LAST = 2'(WB_HOLD - 1);
`ifdef FSM_ALU_MULDIV_EN
    localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
`ifdef FSM_ALU_MULDIV_EN
        S_MD_ISSUE,
        S_MD_WAIT,
`endif
        S_WRITEBACK,
        S_DONE,
        S_TRAP
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] wb_cnt_q, wb_cnt_d;
    logic       sel_wb_md_q, sel_wb_md_d;
`ifdef FSM_ALU_MULDIV_EN
    logic [7:0] md_cnt_q, md_cnt_d;
`endif

    logic       load_pc, load_regfile, load_rs1, load_rs2, load_alu, load_imm;
    logic       sel_alu_a, sel_alu_b, sel_alu_32b, sub_sra;
    logic       md_start, sel_wb_md, done, trap;
    logic [2:0] md_op;

    logic       is_r, is_w, is_md;

    assign is_r  = bus.code[12] | bus.code[14];
    assign is_w  = bus.code[6]  | bus.code[14];
    assign is_md = is_r & (bus.insn[31:25] == 7'b0000001);

    always_comb begin
        state_d      = state_q;
        wb_cnt_d     = '0;
        sel_wb_md_d  = 1'b0;
`ifdef FSM_ALU_MULDIV_EN
        md_cnt_d     = '0;
`endif
        load_pc      = 1'b0;
        load_regfile = 1'b0;
        load_rs1     = 1'b0;
        load_rs2     = 1'b0;
        load_alu     = 1'b0;
        load_imm     = 1'b0;
        sel_alu_a    = 1'b0;
        sel_alu_b    = 1'b0;
        sel_alu_32b  = 1'b0;
        sub_sra      = 1'b0;
        md_start     = 1'b0;
        md_op        = '0;
        sel_wb_md    = 1'b0;
        done         = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_DECODE;
            end
            S_DECODE: begin
                load_rs1 = 1'b1;
                load_rs2 = 1'b1;
                load_imm = 1'b1;
                if (!W_OK && is_w) begin
                    state_d = S_TRAP;
                end else if (is_md) begin
`ifdef FSM_ALU_MULDIV_EN
                    state_d = S_MD_ISSUE;
`else
                    state_d = S_TRAP;
`endif
                end else if (is_r) begin
                    state_d = S_EXEC_R;
                end else begin
                    state_d = S_EXEC_I;
                end
            end
            S_EXEC_R: begin
                load_alu    = 1'b1;
                sub_sra     = bus.insn[30];
                sel_alu_32b = bus.code[14] & W_OK;
                state_d     = S_WRITEBACK;
            end
            S_EXEC_I: begin
                load_alu    = 1'b1;
                sel_alu_b   = 1'b1;
                sel_alu_a   = bus.code[5];
                // insn[30] selects SRA only for the shift-right immediate form
                sub_sra     = bus.insn[30] & (bus.insn[14:12] == 3'b101);
                sel_alu_32b = bus.code[6] & W_OK;
                state_d     = S_WRITEBACK;
            end
`ifdef FSM_ALU_MULDIV_EN
            S_MD_ISSUE: begin
                md_start    = 1'b1;
                md_op       = bus.insn[14:12];
                sel_alu_32b = bus.code[14] & W_OK;
                state_d     = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                md_op = bus.insn[14:12];
                // a result arriving on the final allowed cycle still wins
                if (bus.md_done) begin
                    sel_wb_md_d = 1'b1;
                    state_d     = S_WRITEBACK;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    md_cnt_d = md_cnt_q + 8'd1;
                end
            end
`endif
            S_WRITEBACK: begin
                load_regfile = 1'b1;
                sel_wb_md    = sel_wb_md_q;
                sel_wb_md_d  = sel_wb_md_q;
                if (wb_cnt_q == WB_LAST) begin
                    load_pc = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wb_cnt_d = wb_cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wb_cnt_q    <= '0;
            sel_wb_md_q <= 1'b0;
`ifdef FSM_ALU_MULDIV_EN
            md_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wb_cnt_q    <= wb_cnt_d;
            sel_wb_md_q <= sel_wb_md_d;
`ifdef FSM_ALU_MULDIV_EN
            md_cnt_q    <= md_cnt_d;
`endif
        end
    end

    assign bus.load_pc      = load_pc;
    assign bus.load_regfile = load_regfile;
    assign bus.load_rs1     = load_rs1;
    assign bus.load_rs2     = load_rs2;
    assign bus.load_alu     = load_alu;
    assign bus.load_imm     = load_imm;
    assign bus.sel_alu_a    = sel_alu_a;
    assign bus.sel_alu_b    = sel_alu_b;
    assign bus.sel_alu_32b  = sel_alu_32b;
    assign bus.sub_sra      = sub_sra;
    assign bus.md_start     = md_start;
    assign bus.md_op        = md_op;
    assign bus.sel_wb_md    = sel_wb_md;
    assign bus.done         = done;
    assign bus.trap         = trap;

    // Instruction/class bits this controller does not decode
    logic unused_inputs;
`ifdef FSM_ALU_MULDIV_EN
    assign unused_inputs = ^{bus.insn[24:15], bus.insn[11:0], bus.code[31:15],
                             bus.code[13], bus.code[11:7], bus.code[4:0]};
`else
    assign unused_inputs = ^{bus.insn[24:15], bus.insn[11:0], bus.code[31:15],
                             bus.code[13], bus.code[11:7], bus.code[4:0],
                             bus.md_done};
`endif
endmodule

// File: tb/tb_fsm_alu_mc.sv
// tb_fsm_alu_mc: directed self-checking bench for fsm_alu_mc.
// dut64: XLEN=64, MD_TIMEOUT=4, WB_HOLD=1.  dut32: XLEN=32, WB_HOLD=2.
// Each row drives {rst,start,md_done} for one cycle and lists the expected
// packed outputs seen during that cycle (cycle 1 = the cycle start is high).
module tb_fsm_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fsm_alu_mc_if if64 ();
    fsm_alu_mc_if if32 ();

    fsm_alu_mc #(.XLEN(64), .MD_TIMEOUT(4), .WB_HOLD(1)) dut64 (
        .clk(clk), .rst(rst), .bus(if64)
    );
    fsm_alu_mc #(.XLEN(32), .MD_TIMEOUT(64), .WB_HOLD(2)) dut32 (
        .clk(clk), .rst(rst), .bus(if32)
    );

    // Packed output layout:
    // {load_pc, load_regfile, load_rs1, load_rs2, load_alu, load_imm,
    //  sel_alu_a, sel_alu_b, sel_alu_32b, sub_sra, md_start, md_op[2:0],
    //  sel_wb_md, done, trap}
    localparam bit [16:0] PC   = 17'h10000;
    localparam bit [16:0] RF   = 17'h08000;
    localparam bit [16:0] DEC  = 17'h06800;
    localparam bit [16:0] ALU  = 17'h01000;
    localparam bit [16:0] SA   = 17'h00400;
    localparam bit [16:0] SB   = 17'h00200;
    localparam bit [16:0] W32  = 17'h00100;
    localparam bit [16:0] SUB  = 17'h00080;
    localparam bit [16:0] MDS  = 17'h00040;
    localparam bit [16:0] OP4  = 17'h00020;
    localparam bit [16:0] WBMD = 17'h00004;
    localparam bit [16:0] DN   = 17'h00002;
    localparam bit [16:0] TR   = 17'h00001;

    function automatic bit [16:0] pack64();
        return {if64.load_pc, if64.load_regfile, if64.load_rs1, if64.load_rs2,
                if64.load_alu, if64.load_imm, if64.sel_alu_a, if64.sel_alu_b,
                if64.sel_alu_32b, if64.sub_sra, if64.md_start, if64.md_op,
                if64.sel_wb_md, if64.done, if64.trap};
    endfunction

    function automatic bit [16:0] pack32();
        return {if32.load_pc, if32.load_regfile, if32.load_rs1, if32.load_rs2,
                if32.load_alu, if32.load_imm, if32.sel_alu_a, if32.sel_alu_b,
                if32.sel_alu_32b, if32.sub_sra, if32.md_start, if32.md_op,
                if32.sel_wb_md, if32.done, if32.trap};
    endfunction

    function automatic bit [19:0] rw(bit r, bit s, bit m, bit [16:0] e);
        return {r, s, m, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit r, s, m;
        bit [16:0] e, o64, o32;
        bit [19:0] q[$];
        q = '{rw(1, 1, 1, 0), rw(1, 1, 0, 0), rw(0, 0, 0, 0)};
        if64.insn = 32'h0000_0033; if64.code = 32'h0000_1000;
        if32.insn = 32'h0000_0033; if32.code = 32'h0000_1000;
        rst = 1'b1; if64.start = 1'b1; if32.start = 1'b1;
        step();
        foreach (q[i]) begin
            {r, s, m, e} = q[i];
            rst = r; if64.start = s; if32.start = s;
            if64.md_done = m; if32.md_done = m;
            #1;
            o64 = pack64(); o32 = pack32();
            checks++;
            if (o64 !== e) begin
                $display("FAIL reset64 row%0d: got %h want %h", i, o64, e);
                failures++;
            end
            checks++;
            if (o32 !== e) begin
                $display("FAIL reset32 row%0d: got %h want %h", i, o32, e);
                failures++;
            end
            step();
        end
    endtask

    task automatic test_alu_r();
        bit [31:0] insns [3] = '{32'h0000_0033, 32'h4000_0033, 32'h0000_003B};
        bit [31:0] codes [3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_4000};
        bit [16:0] exs   [3] = '{ALU, ALU | SUB, ALU | W32};
        bit [16:0] e [6];
        bit [16:0] o;
        for (int v = 0; v < 3; v++) begin
            e = '{0, DEC, exs[v], RF | PC, DN, 0};
            if64.insn = insns[v]; if64.code = codes[v]; if64.start = 1'b1;
            for (int c = 0; c < 6; c++) begin
                #1 o = pack64();
                checks++;
                if (o !== e[c]) begin
                    $display("FAIL alu_r v%0d cyc%0d: got %h want %h", v, c + 1, o, e[c]);
                    failures++;
                end
                step();
                if64.start = 1'b0;
            end
        end
    endtask

    task automatic test_alu_i();
        bit [31:0] insns [3] = '{32'h4000_501B, 32'h0000_1097, 32'h4000_0013};
        bit [31:0] codes [3] = '{32'h0000_0040, 32'h0000_0020, 32'h0000_0010};
        bit [16:0] exs   [3] = '{ALU | SB | W32 | SUB, ALU | SA | SB, ALU | SB};
        bit [16:0] e [6];
        bit [16:0] o;
        for (int v = 0; v < 3; v++) begin
            e = '{0, DEC, exs[v], RF | PC, DN, 0};
            if64.insn = insns[v]; if64.code = codes[v]; if64.start = 1'b1;
            for (int c = 0; c < 6; c++) begin
                #1 o = pack64();
                checks++;
                if (o !== e[c]) begin
                    $display("FAIL alu_i v%0d cyc%0d: got %h want %h", v, c + 1, o, e[c]);
                    failures++;
                end
                step();
                if64.start = 1'b0;
            end
        end
    endtask

    task automatic test_xlen32();
        bit [31:0] insns [5] = '{32'h0000_003B, 32'h4000_501B, 32'h0200_003B,
                                 32'h0000_0033, 32'h4000_5013};
        bit [31:0] codes [5] = '{32'h0000_4000, 32'h0000_0040, 32'h0000_4000,
                                 32'h0000_1000, 32'h0000_0010};
        bit [16:0] e [5][7] = '{
            '{0, DEC, TR, 0, 0, 0, 0},
            '{0, DEC, TR, 0, 0, 0, 0},
            '{0, DEC, TR, 0, 0, 0, 0},
            '{0, DEC, ALU, RF, RF | PC, DN, 0},
            '{0, DEC, ALU | SB | SUB, RF, RF | PC, DN, 0}
        };
        int n [5] = '{4, 4, 4, 7, 7};
        bit [16:0] o;
        for (int v = 0; v < 5; v++) begin
            if32.insn = insns[v]; if32.code = codes[v]; if32.start = 1'b1;
            for (int c = 0; c < n[v]; c++) begin
                #1 o = pack32();
                checks++;
                if (o !== e[v][c]) begin
                    $display("FAIL xlen32 v%0d cyc%0d: got %h want %h", v, c + 1, o, e[v][c]);
                    failures++;
                end
                step();
                if32.start = 1'b0;
            end
        end
    endtask

    task automatic test_muldiv();
        bit r, s, m;
        bit [16:0] e, o;
        bit [19:0] q[$];
`ifdef FSM_ALU_MULDIV_EN
        bit [31:0] insns [3] = '{32'h0200_003B, 32'h0200_4033, 32'h0200_4033};
        bit [31:0] codes [3] = '{32'h0000_4000, 32'h0000_1000, 32'h0000_1000};
        for (int v = 0; v < 3; v++) begin
            case (v)
                0: q = '{rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 1, MDS | W32),
                         rw(0, 0, 0, 0), rw(0, 0, 0, 0), rw(0, 0, 0, 0),
                         rw(0, 0, 1, 0), rw(0, 0, 0, RF | PC | WBMD),
                         rw(0, 0, 0, DN), rw(0, 0, 0, 0)};
                1: q = '{rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 0, MDS | OP4),
                         rw(0, 0, 0, OP4), rw(0, 0, 0, OP4), rw(0, 0, 0, OP4),
                         rw(0, 0, 0, OP4), rw(0, 0, 0, TR), rw(0, 0, 0, 0)};
                default: q = '{rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 0, MDS | OP4),
                         rw(0, 0, 0, OP4), rw(0, 0, 0, OP4), rw(0, 0, 1, OP4),
                         rw(0, 0, 0, RF | PC | WBMD), rw(0, 0, 0, DN),
                         rw(0, 0, 0, 0)};
            endcase
`else
        bit [31:0] insns [2] = '{32'h0200_0033, 32'h0200_003B};
        bit [31:0] codes [2] = '{32'h0000_1000, 32'h0000_4000};
        for (int v = 0; v < 2; v++) begin
            q = '{rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 1, TR), rw(0, 0, 0, 0)};
`endif
            if64.insn = insns[v]; if64.code = codes[v];
            foreach (q[i]) begin
                {r, s, m, e} = q[i];
                rst = r; if64.start = s; if64.md_done = m;
                #1 o = pack64();
                checks++;
                if (o !== e) begin
                    $display("FAIL muldiv v%0d cyc%0d: got %h want %h", v, i + 1, o, e);
                    failures++;
                end
                step();
            end
            if64.md_done = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bit r, s, m;
        bit [16:0] e, o;
        bit [19:0] q[$];
`ifdef FSM_ALU_MULDIV_EN
        q = '{rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 0, MDS | OP4),
              rw(0, 0, 0, OP4), rw(1, 0, 0, OP4), rw(1, 1, 0, 0),
              rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 0, MDS | OP4),
              rw(0, 0, 0, OP4), rw(0, 0, 0, OP4), rw(0, 0, 0, OP4),
              rw(0, 0, 1, OP4), rw(0, 0, 0, RF | PC | WBMD), rw(0, 0, 0, DN),
              rw(0, 0, 0, 0)};
        if64.insn = 32'h0200_4033; if64.code = 32'h0000_1000;
        foreach (q[i]) begin
            {r, s, m, e} = q[i];
            rst = r; if64.start = s; if64.md_done = m;
            #1 o = pack64();
            checks++;
            if (o !== e) begin
                $display("FAIL rst_wait cyc%0d: got %h want %h", i + 1, o, e);
                failures++;
            end
            step();
        end
        if64.md_done = 1'b0;
`endif
        q = '{rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 0, ALU), rw(1, 0, 0, RF),
              rw(0, 0, 0, 0), rw(0, 1, 0, 0), rw(0, 0, 0, DEC), rw(0, 0, 0, ALU),
              rw(0, 0, 0, RF), rw(0, 0, 0, RF | PC), rw(0, 0, 0, DN),
              rw(0, 0, 0, 0)};
        if32.insn = 32'h0000_0033; if32.code = 32'h0000_1000;
        foreach (q[i]) begin
            {r, s, m, e} = q[i];
            rst = r; if32.start = s; if32.md_done = m;
            #1 o = pack32();
            checks++;
            if (o !== e) begin
                $display("FAIL rst_wb cyc%0d: got %h want %h", i + 1, o, e);
                failures++;
            end
            step();
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit [16:0] e [16] = '{0, DEC, ALU, RF | PC, DN, 0, DEC, ALU, RF | PC, DN,
                              0, DEC, ALU, RF | PC, DN, 0};
        bit [16:0] o;
        // start held high and md_done asserted throughout: both only matter
        // in IDLE / MD_WAIT respectively
        if64.insn = 32'h0000_0033; if64.code = 32'h0000_1000;
        if64.md_done = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if64.start = (c < 12);
            #1 o = pack64();
            checks++;
            if (o !== e[c]) begin
                $display("FAIL b2b cyc%0d: got %h want %h", c + 1, o, e[c]);
                failures++;
            end
            step();
        end
        if64.start = 1'b0;
        if64.md_done = 1'b0;
    endtask

    initial begin
        if64.insn = '0; if64.code = '0; if64.start = 1'b0; if64.md_done = 1'b0;
        if32.insn = '0; if32.code = '0; if32.start = 1'b0; if32.md_done = 1'b0;
        test_reset();
        test_alu_r();
        test_alu_i();
        test_xlen32();
        test_muldiv();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
